// File: rtl/vu_vmu_ldq_issue_ctrl.sv
// vu_vmu_ldq_issue_ctrl
//
// Load-path sequencer sitting in front of the VMU reorder queue (ROQ).
// Accepts one strided vector-load command at a time, walks the element
// addresses, pairs every D$ load request with a free ROQ tag, and keeps
// count of elements still sitting in the ROQ. Once the whole command has
// been issued and writeback has drained every element, it pulses done.
//
// Ports:
//   clk, reset               clock and synchronous active-high reset
//   cmd_val/cmd_rdy          command handshake
//   cmd_base/stride/vlen     command payload (stride is two's complement)
//   roq_deq_tag_*            free-tag port from the ROQ
//   mem_req_*                D$ load request port
//   wb_data_fire             one element retired from the ROQ this cycle
//   busy                     a command is issuing or draining
//   done                     single-cycle completion pulse

module vu_vmu_ldq_issue_ctrl #(
    parameter int ADDR_SIZE    = 32,
    parameter int VLEN_SIZE    = 9,
    parameter int ROQ_TAG_SIZE = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_val,
    output logic                    cmd_rdy,
    input  logic [ADDR_SIZE-1:0]    cmd_base,
    input  logic [ADDR_SIZE-1:0]    cmd_stride,
    input  logic [VLEN_SIZE-1:0]    cmd_vlen,
    input  logic [ROQ_TAG_SIZE-1:0] roq_deq_tag_bits,
    input  logic                    roq_deq_tag_val,
    output logic                    roq_deq_tag_rdy,
    output logic                    mem_req_val,
    input  logic                    mem_req_rdy,
    output logic [ADDR_SIZE-1:0]    mem_req_addr,
    output logic [ROQ_TAG_SIZE-1:0] mem_req_tag,
    input  logic                    wb_data_fire,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDR_SIZE-1:0]   addr_q, addr_d;
    logic [ADDR_SIZE-1:0]   stride_q, stride_d;
    logic [VLEN_SIZE-1:0]   remain_q, remain_d;
    logic [VLEN_SIZE-1:0]   outstanding_q, outstanding_d;
    logic                   done_q, done_d;

    logic                   cmd_fire;
    logic                   req_fire;
    logic                   in_issue;

    // Handshake outputs. Everything is forced low while reset is held,
    // since a synchronous reset leaves the old state visible until the edge.
    always_comb begin
        in_issue        = (state_q == ISSUE) && !reset;
        cmd_rdy         = (state_q == IDLE) && !reset;
        busy            = (state_q != IDLE) && !reset;
        done            = done_q && !reset;
        mem_req_val     = in_issue && roq_deq_tag_val;
        roq_deq_tag_rdy = in_issue && mem_req_rdy;
        mem_req_addr    = addr_q;
        mem_req_tag     = roq_deq_tag_bits;
        cmd_fire        = cmd_val && cmd_rdy;
        // Tag dequeue and D$ acceptance must happen together, so a request
        // only counts when both sides are ready in the same cycle.
        req_fire        = in_issue && roq_deq_tag_val && mem_req_rdy;
    end

    // Next-state logic for the command sequencer.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        stride_d = stride_q;
        remain_d = remain_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    addr_d   = cmd_base;
                    stride_d = cmd_stride;
                    remain_d = cmd_vlen;
                    // An empty command completes without ever leaving IDLE.
                    if (cmd_vlen == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (req_fire) begin
                    addr_d   = addr_q + stride_q;
                    remain_d = remain_q - VLEN_SIZE'(1);
                    if (remain_q == VLEN_SIZE'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (outstanding_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outstanding-element counter, independent of the sequencer state so
    // early writebacks during ISSUE are accounted for. A retire seen with
    // nothing outstanding is a protocol error and is simply ignored.
    always_comb begin
        outstanding_d = outstanding_q;
        unique case ({req_fire, wb_data_fire})
            2'b10: outstanding_d = outstanding_q + VLEN_SIZE'(1);
            2'b01: begin
                if (outstanding_q != '0) begin
                    outstanding_d = outstanding_q - VLEN_SIZE'(1);
                end
            end
            default: outstanding_d = outstanding_q;
        endcase
    end

    // State registers. Reset abandons any command in flight, including a
    // pending done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            stride_q      <= '0;
            remain_q      <= '0;
            outstanding_q <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            stride_q      <= stride_d;
            remain_q      <= remain_d;
            outstanding_q <= outstanding_d;
            done_q        <= done_d;
        end
    end

endmodule
